// File: rtl/write_buffer.sv
// Store-side write buffer: gathers up to DEPTH words, drains them as sequential bus writes.
// Optional WRITE_BUFFER_AUTO_DRAIN_EN: a push that fills the buffer starts the drain.
module write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 30
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [31:0]                push_data,
    input  logic [3:0]                 push_byte_enable,
    input  logic [ADDR_WIDTH-1:0]      push_addr,
    output logic                       push_ready,
    input  logic                       flush,
    input  logic                       clear,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH-1:0]      bus_addr,
    output logic [31:0]                bus_write_data,
    output logic [3:0]                 bus_byte_enable,
    output logic                       bus_write,
    input  logic                       bus_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                state;
    state_t                state_next;
    logic [IW-1:0]         index;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           data_mem [DEPTH];
    logic [3:0]            be_mem   [DEPTH];

    logic                  accept;
    logic                  last;
    logic                  full_drain;
    logic [CW-1:0]         count_inc;

    assign push_ready      = (state == IDLE) && (count < CW'(DEPTH));
    assign busy            = (state == DRAIN);
    assign bus_write       = busy;
    assign bus_addr        = base + ADDR_WIDTH'(index);
    assign bus_write_data  = data_mem[index];
    assign bus_byte_enable = be_mem[index];

    always_comb begin
        accept     = push && push_ready;
        count_inc  = count + CW'(accept);
        last       = (CW'(index) == count - CW'(1));
`ifdef WRITE_BUFFER_AUTO_DRAIN_EN
        full_drain = accept && (count_inc == CW'(DEPTH));
`else
        full_drain = 1'b0;
`endif
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!clear && ((flush && count_inc != '0) || full_drain))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (bus_ready && last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            index <= '0;
            base  <= '0;
            done  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                be_mem[i]   <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    index <= '0;
                    if (clear) begin
                        count <= '0;
                    end else begin
                        if (accept) begin
                            data_mem[count[IW-1:0]] <= push_data;
                            be_mem[count[IW-1:0]]   <= push_byte_enable;
                            if (count == '0)
                                base <= push_addr;
                        end
                        count <= count_inc;
                        // Empty flush completes immediately with no bus traffic
                        if (flush && count_inc == '0)
                            done <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus_ready) begin
                        if (last) begin
                            count <= '0;
                            index <= '0;
                            done  <= 1'b1;
                        end else begin
                            index <= index + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: directed stores, monitor checks every bus write.
module tb_write_buffer;

    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          push;
    logic [31:0]   push_data;
    logic [3:0]    push_byte_enable;
    logic [AW-1:0] push_addr;
    logic          push_ready;
    logic          flush;
    logic          clear;
    logic [2:0]    count;
    logic          busy;
    logic          done;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_write_data;
    logic [3:0]    bus_byte_enable;
    logic          bus_write;
    logic          bus_ready;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    logic [65:0] exp_q [$];

    write_buffer #(.DEPTH(4), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .push             (push),
        .push_data        (push_data),
        .push_byte_enable (push_byte_enable),
        .push_addr        (push_addr),
        .push_ready       (push_ready),
        .flush            (flush),
        .clear            (clear),
        .count            (count),
        .busy             (busy),
        .done             (done),
        .bus_addr         (bus_addr),
        .bus_write_data   (bus_write_data),
        .bus_byte_enable  (bus_byte_enable),
        .bus_write        (bus_write),
        .bus_ready        (bus_ready)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [65:0] act, logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void expect_wr(logic [AW-1:0] a, logic [31:0] d, logic [3:0] be);
        exp_q.push_back({a, d, be});
    endfunction

    // Monitor: pops on each transfer, checks outputs held across stalls
    logic [65:0] held;
    logic        have_held = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            have_held = 1'b0;
        end else if (bus_write) begin
            if (have_held)
                chk("stall_hold", {bus_addr, bus_write_data, bus_byte_enable}, held);
            if (bus_ready) begin
                writes++;
                have_held = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {bus_addr, bus_write_data, bus_byte_enable}, 66'h0);
                    errors += (checks > 0 && {bus_addr, bus_write_data, bus_byte_enable} == 66'h0) ? 1 : 0;
                end else begin
                    chk("bus_write", {bus_addr, bus_write_data, bus_byte_enable}, exp_q.pop_front());
                end
            end else begin
                held      = {bus_addr, bus_write_data, bus_byte_enable};
                have_held = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(logic [AW-1:0] a, logic [31:0] d, logic [3:0] be);
        push             = 1'b1;
        push_addr        = a;
        push_data        = d;
        push_byte_enable = be;
        step();
        push = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic wait_done(string nm, int exp_writes);
        int n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk({nm, "_done"}, 66'(done), 66'd1);
        chk({nm, "_count"}, 66'(count), 66'd0);
        chk({nm, "_idle"}, 66'(bus_write), 66'd0);
        step();
        chk({nm, "_done_pulse"}, 66'(done), 66'd0);
        chk({nm, "_writes"}, 66'(writes), 66'(exp_writes));
        chk({nm, "_queue"}, 66'(exp_q.size()), 66'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        push = 1'b0; push_data = '0; push_byte_enable = '0; push_addr = '0;
        flush = 1'b0; clear = 1'b0; bus_ready = 1'b1;
        #12;
        chk("rst_bus_write", 66'(bus_write), 66'd0);
        chk("rst_count", 66'(count), 66'd0);
        chk("rst_push_ready", 66'(push_ready), 66'd1);
        chk("rst_done", 66'(done), 66'd0);
        reset_n = 1'b1;
        step();

        // Basic drain with exact latency
        writes = 0;
        do_push(30'h100, 32'hA, 4'hF);
        do_push(30'h200, 32'hB, 4'hF);
        do_push(30'h300, 32'hC, 4'hF);
        chk("t1_count", 66'(count), 66'd3);
        expect_wr(30'h100, 32'hA, 4'hF);
        expect_wr(30'h101, 32'hB, 4'hF);
        expect_wr(30'h102, 32'hC, 4'hF);
        do_flush();
        chk("t1_latency", 66'(bus_write), 66'd1);
        step(); step(); step();
        chk("t1_n_cycles", 66'(done), 66'd1);
        wait_done("t1", 3);

        // Backpressure on word 2
        writes = 0;
        do_push(30'h100, 32'hA, 4'hF);
        do_push(30'h100, 32'hB, 4'hF);
        do_push(30'h100, 32'hC, 4'hF);
        expect_wr(30'h100, 32'hA, 4'hF);
        expect_wr(30'h101, 32'hB, 4'hF);
        expect_wr(30'h102, 32'hC, 4'hF);
        do_flush();
        step();
        bus_ready = 1'b0;
        step(); step();
        chk("t2_stalled", 66'(writes), 66'd1);
        bus_ready = 1'b1;
        wait_done("t2", 3);

        // Full buffer, dropped fifth push
        writes = 0;
        bus_ready = 1'b0;
        do_push(30'h200, 32'h10, 4'h1);
        do_push(30'h000, 32'h11, 4'h2);
        do_push(30'h000, 32'h12, 4'h4);
        do_push(30'h000, 32'h13, 4'h8);
        expect_wr(30'h200, 32'h10, 4'h1);
        expect_wr(30'h201, 32'h11, 4'h2);
        expect_wr(30'h202, 32'h12, 4'h4);
        expect_wr(30'h203, 32'h13, 4'h8);
        chk("t3_count", 66'(count), 66'd4);
        chk("t3_push_ready", 66'(push_ready), 66'd0);
`ifdef WRITE_BUFFER_AUTO_DRAIN_EN
        chk("t3_auto_busy", 66'(busy), 66'd1);
`else
        chk("t3_idle_busy", 66'(busy), 66'd0);
`endif
        do_push(30'h000, 32'hDEAD, 4'hF);
        chk("t3_count_held", 66'(count), 66'd4);
`ifndef WRITE_BUFFER_AUTO_DRAIN_EN
        chk("t3_still_idle", 66'(busy), 66'd0);
        do_flush();
`endif
        bus_ready = 1'b1;
        wait_done("t3", 4);

        // Push and flush together with one word held
        writes = 0;
        do_push(30'h300, 32'h55, 4'h3);
        expect_wr(30'h300, 32'h55, 4'h3);
        expect_wr(30'h301, 32'h66, 4'hC);
        flush = 1'b1;
        do_push(30'h999, 32'h66, 4'hC);
        flush = 1'b0;
        wait_done("t4", 2);

        // Empty flush: done only
        writes = 0;
        do_flush();
        chk("t5_done", 66'(done), 66'd1);
        chk("t5_no_write", 66'(bus_write), 66'd0);
        step();
        chk("t5_done_pulse", 66'(done), 66'd0);
        chk("t5_writes", 66'(writes), 66'd0);

        // Clear beats push
        do_push(30'h40, 32'h1, 4'hF);
        clear = 1'b1;
        do_push(30'h40, 32'h2, 4'hF);
        clear = 1'b0;
        chk("t6_count", 66'(count), 66'd0);
        chk("t6_no_done", 66'(done), 66'd0);

        // Address wrap
        writes = 0;
        do_push(30'h3FFFFFFF, 32'h77, 4'h5);
        do_push(30'h0, 32'h88, 4'hA);
        expect_wr(30'h3FFFFFFF, 32'h77, 4'h5);
        expect_wr(30'h0, 32'h88, 4'hA);
        do_flush();
        wait_done("t7", 2);

        // Reset during word 2
        writes = 0;
        do_push(30'h400, 32'h1, 4'hF);
        do_push(30'h400, 32'h2, 4'hF);
        do_push(30'h400, 32'h3, 4'hF);
        expect_wr(30'h400, 32'h1, 4'hF);
        do_flush();
        step();
        reset_n = 1'b0;
        #1;
        chk("t8_async_write", 66'(bus_write), 66'd0);
        chk("t8_async_count", 66'(count), 66'd0);
        #10;
        reset_n = 1'b1;
        step();
        chk("t8_idle", 66'(busy), 66'd0);
        chk("t8_count", 66'(count), 66'd0);
        chk("t8_push_ready", 66'(push_ready), 66'd1);
        chk("t8_writes", 66'(writes), 66'd1);
        chk("t8_queue", 66'(exp_q.size()), 66'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
